// File: rtl/crc_pkg.sv
// Shared types and helpers for the multi-cycle CRC engine.
// Holds the FSM state encoding, a bit-reversal helper and the counter sizing rule.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } crcState_e;

  // Widest CRC register the reversal helper handles.
  localparam int MAX_CRC_W = 64;

  function automatic int cntWidth(input int steps);
    return $clog2(steps + 1);
  endfunction

  // Reverses the low 'width' bits of value; bits above 'width' come back as zero.
  function automatic logic [MAX_CRC_W-1:0] reverseBits(input logic [MAX_CRC_W-1:0] value,
                                                       input int width);
    logic [MAX_CRC_W-1:0] result;
    result = '0;
    for (int i = 0; i < MAX_CRC_W; i++) begin
      if (i < width) result[width-1-i] = value[i];
    end
    return result;
  endfunction

endpackage

// File: rtl/crc_step.sv
// Combinational CRC update over STEP_W message bits, bits[STEP_W-1] entering first.
// Unrolled so one engine cycle can consume a whole chunk.
module crc_step #(
  parameter int                CRC_W  = 32,
  parameter logic [CRC_W-1:0]  POLY   = 32'h04C11DB7,
  parameter int                STEP_W = 8
) (
  input  logic [CRC_W-1:0]  crcIn,
  input  logic [STEP_W-1:0] bits,
  output logic [CRC_W-1:0]  crcOut
);

  logic feedback;

  always_comb begin
    crcOut   = crcIn;
    feedback = 1'b0;
    for (int i = STEP_W - 1; i >= 0; i--) begin
      feedback = crcOut[CRC_W-1] ^ bits[i];
      crcOut   = (crcOut << 1) ^ (feedback ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_engine.sv
// Multi-cycle CRC engine: accepts a DATA_W word, steps STEP_W bits per cycle and
// strobes the (optionally chained) CRC result for one cycle when the word is consumed.
module crc_engine
  import crc_pkg::*;
#(
  parameter int               DATA_W      = 136,
  parameter int               CRC_W       = 32,
  parameter logic [CRC_W-1:0] POLY        = 32'h04C11DB7,
  parameter logic [CRC_W-1:0] INIT        = 32'hFFFFFFFF,
  parameter logic [CRC_W-1:0] XOR_OUT     = 32'h00000000,
  parameter int               STEP_W      = 8,
  parameter bit               REFLECT_IN  = 1'b0,
  parameter bit               REFLECT_OUT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inDataValid_i,
  input  logic [DATA_W-1:0] inData_i,
  input  logic              inFirst_i,
  output logic              busy_o,
  output logic [CRC_W-1:0]  outData_o,
  output logic              outValid_o
);

  localparam int NUM_STEPS = DATA_W / STEP_W;
  localparam int CNT_W     = cntWidth(NUM_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

  if (DATA_W % STEP_W != 0) begin : gBadStepWidth
    $error("crc_engine: DATA_W must be a multiple of STEP_W");
  end
  if (CRC_W > MAX_CRC_W) begin : gBadCrcWidth
    $error("crc_engine: CRC_W exceeds the supported maximum");
  end

  crcState_e         state;
  logic [DATA_W-1:0] shiftReg;
  logic [CNT_W-1:0]  stepCount;
  logic [CRC_W-1:0]  crcReg;
  logic [STEP_W-1:0] stepBits;
  logic [CRC_W-1:0]  nextCrc;
  logic [CRC_W-1:0]  resultCrc;
  logic              accept;

  assign accept = inDataValid_i && !busy_o;

  // LSB-first words are fed from the bottom of the shift register, so the chunk is
  // reversed to keep the first-consumed bit at the top of stepBits.
  always_comb begin
    stepBits = '0;
    if (REFLECT_IN) begin
      for (int i = 0; i < STEP_W; i++) stepBits[STEP_W-1-i] = shiftReg[i];
    end else begin
      stepBits = shiftReg[DATA_W-1 -: STEP_W];
    end
  end

  crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .STEP_W(STEP_W)
  ) uStep (
    .crcIn (crcReg),
    .bits  (stepBits),
    .crcOut(nextCrc)
  );

  always_comb begin
    resultCrc = nextCrc;
    if (REFLECT_OUT) resultCrc = CRC_W'(reverseBits(MAX_CRC_W'(nextCrc), CRC_W));
    resultCrc = resultCrc ^ XOR_OUT;
  end

  // crcReg is the raw register that persists between words for chaining; only the
  // published outData_o carries the output reflection and XOR.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      shiftReg   <= '0;
      stepCount  <= '0;
      crcReg     <= INIT;
      busy_o     <= 1'b0;
      outValid_o <= 1'b0;
      outData_o  <= '0;
    end else begin
      outValid_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            shiftReg  <= inData_i;
            stepCount <= '0;
            crcReg    <= inFirst_i ? INIT : crcReg;
            busy_o    <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          crcReg    <= nextCrc;
          shiftReg  <= REFLECT_IN ? (shiftReg >> STEP_W) : (shiftReg << STEP_W);
          stepCount <= stepCount + 1'b1;
          if (stepCount == LAST_STEP) begin
            busy_o     <= 1'b0;
            outValid_o <= 1'b1;
            outData_o  <= resultCrc;
            state      <= DONE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_engine.sv
// Directed bench for crc_engine: four configurations (CRC-32 byte-wise, 24-bit chained,
// reflected CRC-32, bit-serial CRC-16) checked against hand-known check values.
module tb_crc_engine;

  logic clk;
  logic rstN;

  logic        validInA, firstInA, busyA, strobeA;
  logic [71:0] dataInA;
  logic [31:0] crcA;

  logic        validInB, firstInB, busyB, strobeB;
  logic [23:0] dataInB;
  logic [31:0] crcB;

  logic        validInC, firstInC, busyC, strobeC;
  logic [71:0] dataInC;
  logic [31:0] crcC;

  logic        validInD, firstInD, busyD, strobeD;
  logic [71:0] dataInD;
  logic [15:0] crcD;

  int checks = 0;
  int errors = 0;

  localparam logic [71:0] MSG_123456789 = 72'h313233343536373839;

  crc_engine #(.DATA_W(72)) uDutA (
    .clk_i(clk), .rst_i(rstN), .inDataValid_i(validInA), .inData_i(dataInA),
    .inFirst_i(firstInA), .busy_o(busyA), .outData_o(crcA), .outValid_o(strobeA)
  );

  crc_engine #(.DATA_W(24)) uDutB (
    .clk_i(clk), .rst_i(rstN), .inDataValid_i(validInB), .inData_i(dataInB),
    .inFirst_i(firstInB), .busy_o(busyB), .outData_o(crcB), .outValid_o(strobeB)
  );

  crc_engine #(.DATA_W(72), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1),
               .XOR_OUT(32'hFFFFFFFF)) uDutC (
    .clk_i(clk), .rst_i(rstN), .inDataValid_i(validInC), .inData_i(dataInC),
    .inFirst_i(firstInC), .busy_o(busyC), .outData_o(crcC), .outValid_o(strobeC)
  );

  crc_engine #(.DATA_W(72), .CRC_W(16), .POLY(16'h1021), .INIT(16'h0000),
               .XOR_OUT(16'h0000), .STEP_W(1)) uDutD (
    .clk_i(clk), .rst_i(rstN), .inDataValid_i(validInD), .inData_i(dataInD),
    .inFirst_i(firstInD), .busy_o(busyD), .outData_o(crcD), .outValid_o(strobeD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Bit-serial MSB-first CRC-32/MPEG-2 reference over msg[nbits-1:0].
  function automatic logic [31:0] crc32Ref(input logic [31:0] seed, input logic [71:0] msg,
                                           input int nbits);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[31] ^ msg[i];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  // Drives one word for exactly one accept edge; returns #1 after that edge.
  task automatic applyStimulus(input int which, input logic [71:0] data, input logic first);
    case (which)
      0: begin validInA = 1'b1; dataInA = data;        firstInA = first; end
      1: begin validInB = 1'b1; dataInB = data[23:0];  firstInB = first; end
      2: begin validInC = 1'b1; dataInC = data;        firstInC = first; end
      default: begin validInD = 1'b1; dataInD = data;  firstInD = first; end
    endcase
    @(posedge clk);
    #1;
    validInA = 1'b0;
    validInB = 1'b0;
    validInC = 1'b0;
    validInD = 1'b0;
  endtask

  // Counts cycles from the current sample point up to and including the strobe.
  task automatic waitStrobe(input int which, input int limit, output int cycles,
                            output int busyCycles);
    logic b;
    logic v;
    cycles     = 0;
    busyCycles = 0;
    repeat (limit) begin
      cycles++;
      case (which)
        0:       begin b = busyA; v = strobeA; end
        1:       begin b = busyB; v = strobeB; end
        2:       begin b = busyC; v = strobeC; end
        default: begin b = busyD; v = strobeD; end
      endcase
      if (b) busyCycles++;
      if (v) return;
      @(posedge clk);
      #1;
    end
    cycles = -1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busyA !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA);
    end
    checks++;
    if (strobeA !== 1'b0 || strobeB !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid: got %b/%b expected 0/0", strobeA, strobeB);
    end
    checks++;
    if (crcA !== 32'h0 || crcD !== 16'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h/%h expected 0/0", crcA, crcD);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single72();
    int cyc, busyCyc;
    applyStimulus(0, MSG_123456789, 1'b1);
    waitStrobe(0, 200, cyc, busyCyc);
    checks++;
    if (cyc !== 10) begin
      errors++; $display("[TB] FAIL single72_latency: got %0d expected 10", cyc);
    end
    checks++;
    if (busyCyc !== 9) begin
      errors++; $display("[TB] FAIL single72_busy: got %0d expected 9", busyCyc);
    end
    checks++;
    if (crcA !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL single72_data: got %h expected 0376e6e7", crcA);
    end
    @(posedge clk);
    #1;
    checks++;
    if (strobeA !== 1'b0 || crcA !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL single72_hold: got valid %b data %h expected 0 0376e6e7",
                         strobeA, crcA);
    end
  endtask

  task automatic test_chain24();
    int cyc, busyCyc;
    applyStimulus(1, 72'h313233, 1'b1);
    waitStrobe(1, 50, cyc, busyCyc);
    checks++;
    if (cyc !== 4 || busyCyc !== 3) begin
      errors++; $display("[TB] FAIL chain_timing: got %0d/%0d expected 4/3", cyc, busyCyc);
    end
    checks++;
    if (crcB !== crc32Ref(32'hFFFFFFFF, 72'h313233, 24)) begin
      errors++; $display("[TB] FAIL chain_word1: got %h expected %h", crcB,
                         crc32Ref(32'hFFFFFFFF, 72'h313233, 24));
    end
    applyStimulus(1, 72'h343536, 1'b0);
    waitStrobe(1, 50, cyc, busyCyc);
    checks++;
    if (cyc !== 4 || crcB !== crc32Ref(32'hFFFFFFFF, 72'h313233343536, 48)) begin
      errors++; $display("[TB] FAIL chain_word2: got %h after %0d expected %h after 4", crcB,
                         cyc, crc32Ref(32'hFFFFFFFF, 72'h313233343536, 48));
    end
    applyStimulus(1, 72'h373839, 1'b0);
    waitStrobe(1, 50, cyc, busyCyc);
    checks++;
    if (cyc !== 4 || crcB !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL chain_word3: got %h after %0d expected 0376e6e7 after 4",
                         crcB, cyc);
    end
    applyStimulus(1, 72'h373839, 1'b1);
    waitStrobe(1, 50, cyc, busyCyc);
    checks++;
    if (cyc !== 4 || crcB !== crc32Ref(32'hFFFFFFFF, 72'h373839, 24)) begin
      errors++; $display("[TB] FAIL chain_reseed: got %h expected %h", crcB,
                         crc32Ref(32'hFFFFFFFF, 72'h373839, 24));
    end
  endtask

  task automatic test_reflect();
    int cyc, busyCyc;
    applyStimulus(2, 72'h393837363534333231, 1'b1);
    waitStrobe(2, 200, cyc, busyCyc);
    checks++;
    if (cyc !== 10 || crcC !== 32'hCBF43926) begin
      errors++; $display("[TB] FAIL reflect_data: got %h after %0d expected cbf43926 after 10",
                         crcC, cyc);
    end
  endtask

  task automatic test_crc16_serial();
    int cyc, busyCyc;
    applyStimulus(3, MSG_123456789, 1'b1);
    waitStrobe(3, 200, cyc, busyCyc);
    checks++;
    if (busyCyc !== 72 || cyc !== 73) begin
      errors++; $display("[TB] FAIL crc16_timing: got busy %0d strobe %0d expected 72/73",
                         busyCyc, cyc);
    end
    checks++;
    if (crcD !== 16'h31C3) begin
      errors++; $display("[TB] FAIL crc16_data: got %h expected 31c3", crcD);
    end
  endtask

  task automatic test_busy_drop();
    int cyc, busyCyc, extra;
    applyStimulus(0, MSG_123456789, 1'b1);
    validInA = 1'b1;
    dataInA  = 72'hDEADBEEFCAFEF00D12;
    firstInA = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    validInA = 1'b0;
    waitStrobe(0, 200, cyc, busyCyc);
    checks++;
    if (cyc !== 6 || crcA !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL drop_data: got %h after %0d expected 0376e6e7 after 6",
                         crcA, cyc);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (strobeA) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("[TB] FAIL drop_extra_strobe: got %0d expected 0", extra);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, busyCyc;
    applyStimulus(0, MSG_123456789, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checks++;
    if (busyA !== 1'b0 || strobeA !== 1'b0 || crcA !== 32'h0) begin
      errors++; $display("[TB] FAIL midrun_reset: got busy %b valid %b data %h expected 0 0 0",
                         busyA, strobeA, crcA);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, MSG_123456789, 1'b1);
    waitStrobe(0, 200, cyc, busyCyc);
    checks++;
    if (cyc !== 10 || crcA !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL midrun_restart: got %h after %0d expected 0376e6e7 after 10",
                         crcA, cyc);
    end
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, MSG_123456789, 1'b0);
    waitStrobe(0, 200, cyc, busyCyc);
    checks++;
    if (crcA !== 32'h0376E6E7) begin
      errors++; $display("[TB] FAIL unseeded_after_reset: got %h expected 0376e6e7", crcA);
    end
  endtask

  initial begin
    rstN     = 1'b0;
    validInA = 1'b0; dataInA = '0; firstInA = 1'b0;
    validInB = 1'b0; dataInB = '0; firstInB = 1'b0;
    validInC = 1'b0; dataInC = '0; firstInC = 1'b0;
    validInD = 1'b0; dataInD = '0; firstInD = 1'b0;
    test_reset();
    test_single72();
    test_chain24();
    test_reflect();
    test_crc16_serial();
    test_busy_drop();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_engine.md
# crc_engine

Parametrised multi-cycle CRC engine, successor of the fixed 136-bit CRC unit. Generalised in data width, CRC width and polynomial, bits processed per cycle and bit reflection, and adds chaining: one CRC computed over a message spread across several input words. Sits between a word-wide producer (packet framer, SiCo player in benches) and a consumer sampling a single-cycle result strobe.

## Interface
- DATA_W, 136, input word width in bits
- CRC_W, 32, CRC register width
- POLY, 32'h04C11DB7, generator polynomial, implicit top bit, CRC_W bits
- INIT, 32'hFFFFFFFF, register seed at message start
- XOR_OUT, 32'h00000000, XORed onto the result
- STEP_W, 8, bits consumed per cycle; DATA_W % STEP_W must be 0 (elaboration error otherwise)
- REFLECT_IN, 0, 0 = word processed MSB-first, 1 = LSB-first
- REFLECT_OUT, 0, 1 = bit-reverse register before XOR_OUT
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- inDataValid_i  in  1  word offered
- inData_i  in  DATA_W  message word
- inFirst_i  in  1  word starts a new message: seed with INIT
- busy_o  out  1  engine stepping, input not accepted
- outData_o  out  CRC_W  CRC of message so far, held until next result
- outValid_o  out  1  single-cycle strobe, outData_o updated

## Operation
- States: IDLE, RUN, DONE. N = DATA_W/STEP_W.
- Accept: inDataValid_i && !busy_o. Words offered while busy_o=1 are dropped, never queued.
- Accept in IDLE or DONE: latch inData_i into shift register, counter := 0, crc := INIT if inFirst_i else current crc; go RUN.
- RUN: each cycle consume STEP_W bits (top bits if REFLECT_IN=0, bottom bits otherwise), shift word, counter++. Per bit b: fb = crc[CRC_W-1]^b; crc = (crc<<1) ^ (fb ? POLY : 0). After step N-1 -> DONE.
- DONE (one cycle): outValid_o=1, outData_o = (REFLECT_OUT ? rev(crc) : crc) ^ XOR_OUT. Accept possible in the same cycle (-> RUN), else -> IDLE.
- Chaining: crc register persists across words; result after each word is the CRC of all words since the last inFirst_i. Unseeded first word after reset uses INIT.
- Reset (any time, incl. mid-RUN): state IDLE, crc := INIT, counter 0, busy_o=0, outValid_o=0, outData_o=0. Partial message discarded.

## Timing
- Accept at edge k: busy_o=1 cycles k+1..k+N, outValid_o=1 cycle k+N+1, busy_o=0 there.
- Latency accept-to-strobe N+1 cycles; back-to-back throughput one word per N+1 cycles.
- outData_o registered, changes only on the edge entering DONE.
- inData_i/inFirst_i sampled only at the accept edge.

## Structure
- Package crc_pkg: state enum (IDLE, RUN, DONE), function reverse bits of CRC_W vector, counter width $clog2(N+1).
- Sub-module crc_step: combinational, unrolled STEP_W-bit update (crc, bits) -> crc, params CRC_W, POLY, STEP_W. Top module holds FSM, counter, shift and crc registers.

## Test plan
- Defaults but DATA_W=72: inData 72'h313233343536373839 ("123456789"), inFirst=1 -> after 10 cycles outValid=1, outData 32'h0376E6E7; busy high exactly 9 cycles.
- DATA_W=24: "123","456","789" (24'h313233, 24'h343536, 24'h373839), inFirst=1,0,0 back-to-back at DONE -> strobes after words 1,2,3; third outData 32'h0376E6E7; third word with inFirst=1 gives CRC of "789" only.
- DATA_W=72, REFLECT_IN=1, REFLECT_OUT=1, XOR_OUT=32'hFFFFFFFF: inData 72'h393837363534333231 -> outData 32'hCBF43926.
- DATA_W=72, CRC_W=16, POLY=16'h1021, INIT=0, STEP_W=1: "123456789" -> 72 busy cycles, outData 16'h31C3.
- Word offered during RUN -> ignored, result unchanged 32'h0376E6E7; no extra strobe.
- rst_i low at RUN step 4 -> busy_o, outValid_o, outData_o 0 immediately; after release a fresh inFirst=1 "123456789" gives 32'h0376E6E7.
